// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared types and constants for the FIFO burst reader.
//   state_e    : burst FSM encoding (IDLE, READ, DRAIN, DONE)
//   SKID_DEPTH : entries in the output buffer that absorbs the FIFO read latency
//   OCC_W      : width of the buffer occupancy count (0..SKID_DEPTH)
// -----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// -----------------------------------------------------------------------------
// stream_skid_buf2
// Two-entry FIFO that catches FIFO read data one cycle after the pop and
// presents it at the head. The caller guarantees it never pushes into a full
// buffer.
// Ports:
//   clk_i        : clock, posedge
//   rst_i        : synchronous active-high reset (empties buffer, clears data)
//   push_i       : write push_data_i at the tail
//   push_data_i  : data to write
//   pop_i        : drop the head entry
//   occ_o        : number of valid entries (0..2)
//   head_o       : data at the head entry
// -----------------------------------------------------------------------------
module stream_skid_buf2
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [OCC_W-1:0]      occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drain-side master for sync_fifo: accepts a burst command of burst_len beats,
// pops exactly that many words and streams them out on a valid/ready
// interface with m_last on the final beat. A 2-entry buffer absorbs the FIFO's
// 1-cycle read latency so the stream sustains one beat per cycle.
// Optional: define FIFO_BURST_READER_STATS_EN to add the stall_cycles output.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start, burst_len  : burst command (sampled only when idle)
//   busy, done        : busy from acceptance until done; done is a 1-cycle pulse
//   fifo_rd_en        : FIFO pop request
//   fifo_data_out     : FIFO read data, valid the cycle after a pop
//   fifo_empty        : FIFO empty flag
//   fifo_cnt          : FIFO occupancy (status only)
//   m_valid/m_ready/m_data/m_last : output stream
//   stall_cycles      : (stats build) stalled-cycle counter, saturating
// -----------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         burst_len,
  output logic                         busy,
  output logic                         done,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_data_out,
  input  logic                         fifo_empty,
  input  logic [$clog2(DATA_DEPTH):0]  fifo_cnt,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_rem_q, issue_rem_d;
  logic [LEN_WIDTH-1:0] beat_rem_q, beat_rem_d;
  logic                 inflight_q;
  logic                 busy_q, done_q;
  logic [OCC_W-1:0]     occ;
  logic                 pop_now;
  logic                 rd_en;

  // Occupancy is status only; kept visible to avoid a dangling input.
  logic unused_fifo_cnt;
  assign unused_fifo_cnt = ^fifo_cnt;

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_out),
    .pop_i       (pop_now),
    .occ_o       (occ),
    .head_o      (m_data)
  );

  // A pop may be issued when the slot it will land in is guaranteed free,
  // counting the head that leaves this cycle; this is what keeps the stream
  // at one beat per cycle under continuous m_ready.
  always_comb begin
    pop_now = (occ != '0) && m_ready;
    rd_en   = (state_q == READ) && (issue_rem_q != '0) && !fifo_empty &&
              (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_now}));
  end

  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q - LEN_WIDTH'(rd_en);
    beat_rem_d  = beat_rem_q - LEN_WIDTH'(pop_now);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          issue_rem_d = burst_len;
          beat_rem_d  = burst_len;
          state_d     = (burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue_rem_q == '0) state_d = DRAIN;
      end
      // Look at the post-handshake count so done follows the last beat directly.
      DRAIN: begin
        if (beat_rem_d == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      beat_rem_q  <= beat_rem_d;
      inflight_q  <= rd_en;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_rd_en = rd_en;
  assign m_valid    = (occ != '0);
  assign m_last     = m_valid && (beat_rem_q == LEN_WIDTH'(1));

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] stall_q;
  logic        stall_inc;

  always_comb begin
    stall_inc = (m_valid && !m_ready) ||
                ((state_q == READ) && (issue_rem_q != '0) && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int DD = 1024;
  localparam int LW = 16;
  localparam int CW = $clog2(DD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy, done, fifo_rd_en;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_cnt      (fifo_cnt),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural sync FIFO: writes land at the next edge, read data one cycle after pop.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend_q[$];
  int            fcount = 0;
  assign fifo_empty = (fcount == 0);
  assign fifo_cnt   = CW'(fcount);

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
    while (pend_q.size() > 0) fq.push_back(pend_q.pop_front());
    fcount <= fq.size();
  end

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int            exp_left    = 0;
  int            beats       = 0;
  int            pops        = 0;
  int            outstanding = 0;
  logic          prev_hold   = 1'b0;
  logic [DW-1:0] prev_data   = '0;

  task automatic push(input logic [DW-1:0] v);
    pend_q.push_back(v);
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_hold   = 1'b0;
      outstanding = 0;
    end else begin
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", fifo_empty, 0);
        pops++;
      end
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
          chk("m_last", m_last, (exp_left == 1) ? 1 : 0);
        end
        exp_left--;
        beats++;
      end
      outstanding = outstanding + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      chk("outstanding_le2", (outstanding <= 2) ? 1 : 0, 1);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic do_start(input int len);
    start     = 1'b1;
    burst_len = LW'(len);
    exp_left  = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (toggle) begin
        @(posedge clk);
        #1 m_ready = ~m_ready;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  int b0, p0;
  bit got;

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: 16 back-to-back beats, latency and done timing
    for (int i = 0; i < 16; i++) push(DW'(i));
    @(posedge clk);
    #1 b0 = beats;
    do_start(16);
    @(negedge clk); chk("t1_lat_c1", m_valid, 0);
    @(negedge clk); chk("t1_lat_c2", m_valid, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t1_no_bubble", m_valid, 1);
    end
    @(negedge clk);
    chk("t1_done_after_last", done, 1);
    chk("t1_valid_off", m_valid, 0);
    chk("t1_fifo_empty", fifo_empty, 1);
    chk("t1_beats", beats - b0, 16);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_low", busy, 0);

    // T2: m_ready toggling, data held during back-pressure
    for (int i = 0; i < 8; i++) push(DW'(32'h100 + i));
    @(posedge clk);
    #1 b0 = beats;
    do_start(8);
    wait_done("t2", 200, 1'b1);
    chk("t2_beats", beats - b0, 8);

    // T3: FIFO trickle-fed, one word every 5 cycles
    b0 = beats;
    do_start(4);
    @(negedge clk);
    chk("t3_busy", busy, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      repeat (5) @(posedge clk);
      #1 push(DW'(32'h200 + k));
    end
`ifdef FIFO_BURST_READER_STATS_EN
    chk("t3_stall_nonzero", (stall_cycles != 0) ? 1 : 0, 1);
`endif
    wait_done("t3", 100, 1'b0);
    chk("t3_beats", beats - b0, 4);

    // T4: zero-length burst
    b0 = beats; p0 = pops;
    do_start(0);
    @(negedge clk);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 1);
    @(negedge clk);
    chk("t4_busy_after", busy, 0);
    chk("t4_done_after", done, 0);
    chk("t4_no_pops", pops - p0, 0);
    chk("t4_no_beats", beats - b0, 0);

    // T5: reset mid-burst, then a fresh burst on the remaining data
    @(posedge clk);
    for (int i = 0; i < 12; i++) push(DW'(32'h300 + i));
    #1;
    @(posedge clk);
    #1 b0 = beats;
    do_start(10);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (beats - b0 >= 3) got = 1'b1;
    end
    chk("t5_three_beats", got, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_rd_en", fifo_rd_en, 0);
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_m_last", m_last, 0);
    chk("t5_rst_m_data", m_data, 0);
    rst = 1'b0;
    exp_q = fq;
    @(posedge clk);
    #1 b0 = beats;
    do_start(2);
    wait_done("t5", 50, 1'b0);
    chk("t5_beats", beats - b0, 2);

    // T6: start while busy is ignored
    for (int i = 0; i < 8; i++) push(DW'(32'h400 + i));
    @(posedge clk);
    #1 b0 = beats; p0 = pops;
    do_start(5);
    start = 1'b1; burst_len = LW'(9);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t6", 100, 1'b0);
    chk("t6_pops", pops - p0, 5);
    chk("t6_beats", beats - b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Drain-side master for sync_fifo. It accepts a burst command of N beats and pops exactly N words from the FIFO read port. It presents those words on a valid/ready stream to the NPU datapath and flags the final beat. It absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so it sustains 1 beat/cycle under continuous ready.

Parameters:
DATA_WIDTH, 32, FIFO/stream word width
DATA_DEPTH, 1024, depth of the attached sync_fifo; sets the fifo_cnt width to $clog2(DATA_DEPTH)+1
LEN_WIDTH, 16, burst length counter width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  burst command strobe; sampled only in IDLE
burst_len  in  LEN_WIDTH  beats in burst; captured with start
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at burst completion
fifo_rd_en  out  1  FIFO pop request
fifo_data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted pop
fifo_empty  in  1  FIFO empty flag
fifo_cnt  in  $clog2(DATA_DEPTH)+1  FIFO occupancy; status only, not used for control
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  stream data
m_last  out  1  marks the final beat of the burst; qualified by m_valid

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, both counters 0, buffer emptied, in-flight flag cleared. Outputs go to 0: busy, done, fifo_rd_en, m_valid, m_last. m_data goes to 0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: when start=1, latch burst_len into issue_rem and beat_rem, then go to READ. If burst_len=0, go straight to DONE (no pops, no beats).
  - READ: issue pops until issue_rem=0, then go to DRAIN.
  - DRAIN: wait until beat_rem=0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in READ, DRAIN and DONE. A start while busy is ignored; burst_len is not re-sampled.
- Pop rule (combinational): fifo_rd_en = (state==READ) && issue_rem!=0 && !fifo_empty && (occ + inflight − pop_now) < 2.
  - occ: buffer occupancy.
  - inflight: a pop was issued last cycle.
  - pop_now: m_valid && m_ready.
  - The path from m_ready to fifo_rd_en is intentional; it is what allows 1 beat/cycle.
  - fifo_rd_en never asserts while fifo_empty=1.
- Each asserted fifo_rd_en decrements issue_rem and sets inflight. On the next cycle fifo_data_out is written into the buffer tail.
- Buffer: 2-entry FIFO, head drives m_data. m_valid=(occ!=0).
  - m_data/m_valid stay stable while m_valid && !m_ready.
  - Write and pop in the same cycle leave occ unchanged.
- Each handshake decrements beat_rem. m_last = m_valid && (beat_rem==1).
- Latency: with a non-empty FIFO and m_ready=1, the first m_valid appears 2 cycles after start is sampled.
- FIFO runs empty mid-burst: stall pops and hold state in READ; no timeout.
- Arithmetic: counters are unsigned LEN_WIDTH; a burst of up to 2^LEN_WIDTH−1 beats needs no wrap handling.
- rst asserted mid-burst: abort immediately to the reset values. Data already popped from the FIFO is discarded. There is no done pulse.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- When defined, add output port stall_cycles [31:0].
  - Counts cycles with m_valid && !m_ready, plus cycles in READ with issue_rem!=0 && fifo_empty.
  - Clears on start acceptance and on rst; saturates at 32'hFFFF_FFFF.
- When undefined, the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_burst_reader_pkg holds:
  - the state enum: IDLE=2'd0, READ=2'd1, DRAIN=2'd2, DONE=2'd3;
  - the constant SKID_DEPTH=2.
- Sub-module stream_skid_buf2 (the 2-entry buffer: push, pop, occ, head data) is natural. Top level keeps the FSM, counters and pop rule.

Test Plan:
- Preload FIFO with 0..15; start, burst_len=16, m_ready=1 → 16 consecutive beats 0..15 with no bubble; m_last on beat 15; done pulse 1 cycle after the last handshake; fifo_empty=1.
- Preload 8 words; burst_len=8; toggle m_ready 1,0,1,0 → data order preserved; m_data held stable on every m_ready=0 cycle; never more than 2 pops outstanding/buffered.
- Empty FIFO; burst_len=4; write 1 word every 5 cycles → fifo_rd_en never high while fifo_empty=1; exactly 4 beats; done after the 4th.
- burst_len=0 → no fifo_rd_en and no m_valid; busy high for 1 cycle, then done pulse.
- Start burst_len=10 and assert rst after 3 beats → all outputs 0 at the next cycle; FSM in IDLE; a new start with burst_len=2 completes normally with remaining FIFO data.
- Start pulsed again while busy → ignored; pop count equals the first burst_len (e.g. 5).
